// File: rtl/operand_join_pkg.sv
// Shared defaults and helpers for the operand pairing stage.
package operand_join_pkg;

  localparam int TOKEN_W    = 16;
  localparam int FIFO_DEPTH = 4;

  // Ceiling log2, usable in parameter defaults.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/operand_join_fifo.sv
// Single-clock circular token buffer with a combinational head and an occupancy counter.
module join_fifo
  import operand_join_pkg::*;
#(
  parameter int N     = TOKEN_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic [AW:0]  level,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage has no reset; only pointers and level define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);

endmodule

// File: rtl/operand_join.sv
// Pairs two independent operand token streams and releases one aligned pair per cycle.
module operand_join
  import operand_join_pkg::*;
#(
  parameter int N     = TOKEN_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         R_IN1,
  input  logic [N-1:0] D_IN1,
  input  logic         R_IN2,
  input  logic [N-1:0] D_IN2,
  output logic         R_OUT1,
  output logic [N-1:0] D_OUT1,
  output logic         R_OUT2,
  output logic [N-1:0] D_OUT2,
  output logic [AW:0]  LVL1,
  output logic [AW:0]  LVL2,
  output logic         OVF1,
  output logic         OVF2
);

  logic [N-1:0] head1;
  logic [N-1:0] head2;
  logic         full1;
  logic         full2;
  logic         empty1;
  logic         empty2;
  logic         pop;
  logic         push1;
  logic         push2;
  logic         r_out;

  // A full FIFO still accepts a token in the cycle its head is consumed.
  assign pop   = EN && !empty1 && !empty2;
  assign push1 = EN && R_IN1 && (!full1 || pop);
  assign push2 = EN && R_IN2 && (!full2 || pop);

  join_fifo #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_fifo1 (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push1),
    .pop   (pop),
    .din   (D_IN1),
    .dout  (head1),
    .level (LVL1),
    .full  (full1),
    .empty (empty1)
  );

  join_fifo #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_fifo2 (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push2),
    .pop   (pop),
    .din   (D_IN2),
    .dout  (head2),
    .level (LVL2),
    .full  (full2),
    .empty (empty2)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_out  <= 1'b0;
      D_OUT1 <= '0;
      D_OUT2 <= '0;
      OVF1   <= 1'b0;
      OVF2   <= 1'b0;
    end else if (EN) begin
      r_out <= pop;
      if (pop) begin
        D_OUT1 <= head1;
        D_OUT2 <= head2;
      end
      if (R_IN1 && !push1) OVF1 <= 1'b1;
      if (R_IN2 && !push2) OVF2 <= 1'b1;
    end
  end

  assign R_OUT1 = r_out;
  assign R_OUT2 = r_out;

endmodule

// File: tb/tb_operand_join.sv
// Scoreboard bench for operand_join: expected operands queue on drive, pop on each released pair.
module tb_operand_join;

  localparam int N = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic         EN;
  logic         R_IN1;
  logic [N-1:0] D_IN1;
  logic         R_IN2;
  logic [N-1:0] D_IN2;
  logic         R_OUT1;
  logic [N-1:0] D_OUT1;
  logic         R_OUT2;
  logic [N-1:0] D_OUT2;
  logic [2:0]   LVL1;
  logic [2:0]   LVL2;
  logic         OVF1;
  logic         OVF2;

  int passed = 0;
  int total  = 0;
  logic [N-1:0] exp1[$];
  logic [N-1:0] exp2[$];

  operand_join dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .R_IN1(R_IN1), .D_IN1(D_IN1), .R_IN2(R_IN2), .D_IN2(D_IN2),
    .R_OUT1(R_OUT1), .D_OUT1(D_OUT1), .R_OUT2(R_OUT2), .D_OUT2(D_OUT2),
    .LVL1(LVL1), .LVL2(LVL2), .OVF1(OVF1), .OVF2(OVF2)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; EN = 1'b1; R_IN1 = 1'b0; R_IN2 = 1'b0; D_IN1 = '0; D_IN2 = '0;
    tick(); tick();
    RST = 1'b1;
    exp1.delete();
    exp2.delete();
  endtask

  task automatic test_reset();
    RST = 1'b0; EN = 1'b1; R_IN1 = 1'b1; R_IN2 = 1'b1; D_IN1 = 16'hFFFF; D_IN2 = 16'hFFFF;
    tick(); tick();
    total++;
    if ({R_OUT1, R_OUT2} !== 2'b00) $display("[TB] FAIL reset_rout: got %b expected 00", {R_OUT1, R_OUT2});
    else passed++;
    total++;
    if ({D_OUT1, D_OUT2} !== 32'h0) $display("[TB] FAIL reset_dout: got %h/%h expected 0000/0000", D_OUT1, D_OUT2);
    else passed++;
    total++;
    if ({LVL1, LVL2} !== 6'd0) $display("[TB] FAIL reset_lvl: got %0d/%0d expected 0/0", LVL1, LVL2);
    else passed++;
    total++;
    if ({OVF1, OVF2} !== 2'b00) $display("[TB] FAIL reset_ovf: got %b expected 00", {OVF1, OVF2});
    else passed++;
    RST = 1'b1; R_IN1 = 1'b0; R_IN2 = 1'b0;
    exp1.delete();
    exp2.delete();
  endtask

  task automatic test_aligned();
    logic [N-1:0] e1, e2;
    R_IN1 = 1'b1; D_IN1 = 16'h0003; R_IN2 = 1'b1; D_IN2 = 16'h0004;
    exp1.push_back(16'h0003); exp2.push_back(16'h0004);
    tick();
    R_IN1 = 1'b0; R_IN2 = 1'b0;
    total++;
    if (R_OUT1 !== 1'b0) $display("[TB] FAIL aligned_nobypass: got R_OUT1=%b expected 0", R_OUT1);
    else passed++;
    tick();
    total++;
    if (R_OUT1 !== 1'b1 || exp1.size() == 0) $display("[TB] FAIL aligned_pair: got R_OUT1=%b expected 1", R_OUT1);
    else begin
      e1 = exp1.pop_front(); e2 = exp2.pop_front();
      if ({R_OUT2, D_OUT1, D_OUT2} !== {1'b1, e1, e2})
        $display("[TB] FAIL aligned_pair: got %b %h/%h expected 1 %h/%h", R_OUT2, D_OUT1, D_OUT2, e1, e2);
      else passed++;
    end
    tick();
    total++;
    if ({R_OUT1, R_OUT2, D_OUT1, D_OUT2} !== {2'b00, 16'h0003, 16'h0004})
      $display("[TB] FAIL aligned_after: got %b%b %h/%h expected 00 0003/0004", R_OUT1, R_OUT2, D_OUT1, D_OUT2);
    else passed++;
  endtask

  task automatic test_skew();
    logic [N-1:0] e1, e2;
    logic [N-1:0] op1 [3];
    logic [N-1:0] op2 [3];
    logic [2:0]   lvl_max;
    op1[0] = 16'h0011; op1[1] = 16'h0022; op1[2] = 16'h0033;
    op2[0] = 16'h000A; op2[1] = 16'h000B; op2[2] = 16'h000C;
    lvl_max = '0;
    do_reset();
    for (int cyc = 0; cyc < 11; cyc++) begin
      R_IN1 = (cyc <= 2);
      D_IN1 = (cyc <= 2) ? op1[cyc] : 16'h0;
      R_IN2 = (cyc >= 5 && cyc <= 7);
      D_IN2 = (cyc >= 5 && cyc <= 7) ? op2[cyc-5] : 16'h0;
      if (R_IN1) exp1.push_back(D_IN1);
      if (R_IN2) exp2.push_back(D_IN2);
      tick();
      if (LVL1 > lvl_max) lvl_max = LVL1;
      total++;
      if (R_OUT1 !== (cyc >= 6 && cyc <= 8)) $display("[TB] FAIL skew_timing: edge %0d got R_OUT1=%b", cyc, R_OUT1);
      else passed++;
      if (R_OUT1) begin
        total++;
        if (exp1.size() == 0 || exp2.size() == 0)
          $display("[TB] FAIL skew_pair: got %h/%h expected no pair", D_OUT1, D_OUT2);
        else begin
          e1 = exp1.pop_front(); e2 = exp2.pop_front();
          if ({R_OUT2, D_OUT1, D_OUT2} !== {1'b1, e1, e2})
            $display("[TB] FAIL skew_pair: got %b %h/%h expected 1 %h/%h", R_OUT2, D_OUT1, D_OUT2, e1, e2);
          else passed++;
        end
      end
    end
    R_IN1 = 1'b0; R_IN2 = 1'b0;
    total++;
    if (lvl_max !== 3'd3) $display("[TB] FAIL skew_lvl_peak: got %0d expected 3", lvl_max);
    else passed++;
    total++;
    if (exp1.size() != 0 || exp2.size() != 0) $display("[TB] FAIL skew_drain: got %0d/%0d left expected 0/0", exp1.size(), exp2.size());
    else passed++;
  endtask

  task automatic test_overflow();
    logic [N-1:0] e1, e2;
    int pairs;
    pairs = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      R_IN1 = 1'b1; D_IN1 = 16'(i + 1);
      if (i < 4) exp1.push_back(D_IN1);
      tick();
      if (i == 3) begin
        total++;
        if (OVF1 !== 1'b0) $display("[TB] FAIL ovf_early: got OVF1=%b expected 0", OVF1);
        else passed++;
      end
    end
    R_IN1 = 1'b0;
    total++;
    if ({OVF1, OVF2, LVL1} !== {2'b10, 3'd4}) $display("[TB] FAIL ovf_full: got OVF1=%b OVF2=%b LVL1=%0d expected 1 0 4", OVF1, OVF2, LVL1);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      R_IN2 = (i < 4); D_IN2 = 16'h0100 + 16'(i);
      if (R_IN2) exp2.push_back(D_IN2);
      tick();
      if (R_OUT1) begin
        pairs++;
        total++;
        if (exp1.size() == 0 || exp2.size() == 0)
          $display("[TB] FAIL ovf_pair: got %h/%h expected no pair", D_OUT1, D_OUT2);
        else begin
          e1 = exp1.pop_front(); e2 = exp2.pop_front();
          if ({R_OUT2, D_OUT1, D_OUT2} !== {1'b1, e1, e2})
            $display("[TB] FAIL ovf_pair: got %b %h/%h expected 1 %h/%h", R_OUT2, D_OUT1, D_OUT2, e1, e2);
          else passed++;
        end
      end
    end
    R_IN2 = 1'b0;
    total++;
    if (pairs != 4) $display("[TB] FAIL ovf_pair_count: got %0d expected 4", pairs);
    else passed++;
    total++;
    if ({OVF1, LVL1, LVL2} !== {1'b1, 3'd0, 3'd0}) $display("[TB] FAIL ovf_sticky: got OVF1=%b LVL=%0d/%0d expected 1 0/0", OVF1, LVL1, LVL2);
    else passed++;
  endtask

  task automatic test_full_pop();
    logic [N-1:0] e1, e2;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      R_IN1 = 1'b1; D_IN1 = 16'h0041 + 16'(i);
      exp1.push_back(D_IN1);
      tick();
    end
    R_IN1 = 1'b0; R_IN2 = 1'b1; D_IN2 = 16'h00B1;
    exp2.push_back(D_IN2);
    tick();
    total++;
    if ({LVL1, LVL2} !== {3'd4, 3'd1}) $display("[TB] FAIL fullpop_setup: got %0d/%0d expected 4/1", LVL1, LVL2);
    else passed++;
    R_IN1 = 1'b1; D_IN1 = 16'h0055; R_IN2 = 1'b0;
    exp1.push_back(D_IN1);
    tick();
    R_IN1 = 1'b0;
    total++;
    if ({LVL1, LVL2, OVF1} !== {3'd4, 3'd0, 1'b0}) $display("[TB] FAIL fullpop_level: got LVL=%0d/%0d OVF1=%b expected 4/0 0", LVL1, LVL2, OVF1);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        R_IN2 = (i <= 4); D_IN2 = 16'h00B1 + 16'(i);
        if (R_IN2) exp2.push_back(D_IN2);
        tick();
      end
      if (R_OUT1) begin
        total++;
        if (exp1.size() == 0 || exp2.size() == 0)
          $display("[TB] FAIL fullpop_pair: got %h/%h expected no pair", D_OUT1, D_OUT2);
        else begin
          e1 = exp1.pop_front(); e2 = exp2.pop_front();
          if ({R_OUT2, D_OUT1, D_OUT2} !== {1'b1, e1, e2})
            $display("[TB] FAIL fullpop_pair: got %b %h/%h expected 1 %h/%h", R_OUT2, D_OUT1, D_OUT2, e1, e2);
          else passed++;
        end
      end
    end
    R_IN2 = 1'b0;
    total++;
    if (exp1.size() != 0 || exp2.size() != 0 || OVF1 !== 1'b0)
      $display("[TB] FAIL fullpop_drain: got %0d/%0d left OVF1=%b expected 0/0 0", exp1.size(), exp2.size(), OVF1);
    else passed++;
  endtask

  task automatic test_freeze();
    logic [N-1:0] e1, e2;
    int pairs;
    pairs = 0;
    do_reset();
    for (int cyc = 0; cyc < 10; cyc++) begin
      EN = !(cyc >= 2 && cyc <= 4);
      R_IN1 = 1'b0; D_IN1 = '0; R_IN2 = 1'b0; D_IN2 = '0;
      case (cyc)
        0: begin R_IN1 = 1'b1; D_IN1 = 16'h0071; R_IN2 = 1'b1; D_IN2 = 16'h00B1; end
        1: begin R_IN1 = 1'b1; D_IN1 = 16'h0072; end
        2, 3, 4: begin R_IN1 = 1'b1; D_IN1 = 16'hDEAD; R_IN2 = 1'b1; D_IN2 = 16'hBEEF; end
        5: begin R_IN2 = 1'b1; D_IN2 = 16'h00B2; end
        6: begin R_IN1 = 1'b1; D_IN1 = 16'h0073; R_IN2 = 1'b1; D_IN2 = 16'h00B3; end
        default: ;
      endcase
      if (EN && R_IN1) exp1.push_back(D_IN1);
      if (EN && R_IN2) exp2.push_back(D_IN2);
      tick();
      if (!EN) begin
        total++;
        if ({R_OUT1, D_OUT1, D_OUT2, LVL1, LVL2} !== {1'b1, 16'h0071, 16'h00B1, 3'd1, 3'd0})
          $display("[TB] FAIL freeze_hold: got %b %h/%h LVL=%0d/%0d expected 1 0071/00B1 1/0", R_OUT1, D_OUT1, D_OUT2, LVL1, LVL2);
        else passed++;
      end else if (R_OUT1) begin
        pairs++;
        total++;
        if (exp1.size() == 0 || exp2.size() == 0)
          $display("[TB] FAIL freeze_pair: got %h/%h expected no pair", D_OUT1, D_OUT2);
        else begin
          e1 = exp1.pop_front(); e2 = exp2.pop_front();
          if ({R_OUT2, D_OUT1, D_OUT2} !== {1'b1, e1, e2})
            $display("[TB] FAIL freeze_pair: got %b %h/%h expected 1 %h/%h", R_OUT2, D_OUT1, D_OUT2, e1, e2);
          else passed++;
        end
      end
    end
    EN = 1'b1; R_IN1 = 1'b0; R_IN2 = 1'b0;
    total++;
    if (pairs != 3 || exp1.size() != 0 || exp2.size() != 0)
      $display("[TB] FAIL freeze_resume: got %0d pairs, %0d/%0d left expected 3, 0/0", pairs, exp1.size(), exp2.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] e1, e2;
    int pairs;
    pairs = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      R_IN1 = (i < 8); D_IN1 = 16'($urandom);
      R_IN2 = (i < 8); D_IN2 = 16'($urandom);
      if (R_IN1) exp1.push_back(D_IN1);
      if (R_IN2) exp2.push_back(D_IN2);
      tick();
      total++;
      if (R_OUT1 !== (i >= 1 && i <= 8)) $display("[TB] FAIL b2b_timing: edge %0d got R_OUT1=%b", i, R_OUT1);
      else passed++;
      if (R_OUT1) begin
        pairs++;
        total++;
        if (exp1.size() == 0 || exp2.size() == 0)
          $display("[TB] FAIL b2b_pair: got %h/%h expected no pair", D_OUT1, D_OUT2);
        else begin
          e1 = exp1.pop_front(); e2 = exp2.pop_front();
          if ({R_OUT2, D_OUT1, D_OUT2} !== {1'b1, e1, e2})
            $display("[TB] FAIL b2b_pair: got %b %h/%h expected 1 %h/%h", R_OUT2, D_OUT1, D_OUT2, e1, e2);
          else passed++;
        end
      end
    end
    R_IN1 = 1'b0; R_IN2 = 1'b0;
    total++;
    if (pairs != 8) $display("[TB] FAIL b2b_count: got %0d expected 8", pairs);
    else passed++;
  endtask

  initial begin
    RST = 1'b0; EN = 1'b1; R_IN1 = 1'b0; R_IN2 = 1'b0; D_IN1 = '0; D_IN2 = '0;
    test_reset();
    test_aligned();
    test_skew();
    test_overflow();
    test_full_pop();
    test_freeze();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
